// File: rtl/pulse_train_gen_pkg.sv
// Shared timer definitions for the pulse train generator and its edge-detector peer:
// state encoding, counter width default and edge-mode encoding.
package pulse_train_gen_pkg;

  localparam int CNT_W_DEF = 16;

  localparam logic EDGE_RISE = 1'b0;
  localparam logic EDGE_FALL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACT   = 2'd1,
    ST_INACT = 2'd2
  } state_e;

  function automatic logic active_level(input logic mode);
    return (mode == EDGE_FALL) ? 1'b0 : 1'b1;
  endfunction

  // A run needs a non-empty active phase and a non-empty inactive phase.
  function automatic logic cfg_ok(input logic [31:0] period, input logic [31:0] width);
    return (period >= 32'd2) && (width >= 32'd1) && (width < period);
  endfunction

endpackage

// File: rtl/pulse_train_gen_if.sv
// Control/status bundle between the timer control logic (master) and the
// pulse train generator (slave).
interface pulse_train_gen_if #(
  parameter int CNT_W = pulse_train_gen_pkg::CNT_W_DEF
) ();

  logic             start_i;
  logic             stop_i;
  logic             edge_mode_i;
  logic [CNT_W-1:0] period_i;
  logic [CNT_W-1:0] width_i;
  logic [CNT_W-1:0] num_i;
  logic             sig_o;
  logic             active_strobe_o;
  logic             busy_o;
  logic             done_o;
  logic             cfg_err_o;

  modport master (
    output start_i, stop_i, edge_mode_i, period_i, width_i, num_i,
    input  sig_o, active_strobe_o, busy_o, done_o, cfg_err_o
  );

  modport slave (
    input  start_i, stop_i, edge_mode_i, period_i, width_i, num_i,
    output sig_o, active_strobe_o, busy_o, done_o, cfg_err_o
  );

endinterface

// File: rtl/pulse_train_gen_phase_counter.sv
// Loadable up-counter timing one ACT or INACT phase; load restarts it at 1 and
// tc_o flags the last cycle of the phase.
module pulse_train_gen_phase_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] term_i,
  output logic             tc_o
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next-count selection: load wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = ONE;
    end else if (en_i) begin
      cnt_d = cnt_q + ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == term_i);

endmodule

// File: rtl/pulse_train_gen.sv
// Programmable pulse train generator: period/width/polarity/count per run,
// start/stop handshake, busy/done/error status, all outputs straight from flops.
module pulse_train_gen
  import pulse_train_gen_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input logic              clk_i,
  input logic              rst_i,
  pulse_train_gen_if.slave bus
);

  localparam logic [CNT_W-1:0] ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ALL1 = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic             sig_q, sig_d;
  logic             strobe_q, strobe_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] width_q, width_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] pulse_q, pulse_d;

  logic             ph_load;
  logic             ph_en;
  logic             ph_tc;
  logic [CNT_W-1:0] ph_term;
  logic             more_pulses;

  pulse_train_gen_phase_counter #(.CNT_W(CNT_W)) u_phase (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (ph_load),
    .en_i   (ph_en),
    .term_i (ph_term),
    .tc_o   (ph_tc)
  );

  // Phase length for the current state and whether another pulse is owed.
  always_comb begin
    ph_term     = (state_q == ST_ACT) ? width_q : (period_q - width_q);
    more_pulses = (num_q == ZERO) || (pulse_q < num_q);
  end

  // Next-state and output logic.
  always_comb begin
    state_d  = state_q;
    sig_d    = sig_q;
    strobe_d = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    mode_d   = mode_q;
    period_d = period_q;
    width_d  = width_q;
    num_d    = num_q;
    pulse_d  = pulse_q;
    ph_load  = 1'b0;
    ph_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        sig_d  = bus.edge_mode_i;
        busy_d = 1'b0;
        // Stop in IDLE suppresses a simultaneous start without flagging an error.
        if (bus.stop_i) begin
          err_d = 1'b0;
        end else if (bus.start_i) begin
          if (cfg_ok(32'(bus.period_i), 32'(bus.width_i))) begin
            state_d  = ST_ACT;
            mode_d   = bus.edge_mode_i;
            period_d = bus.period_i;
            width_d  = bus.width_i;
            num_d    = bus.num_i;
            pulse_d  = ONE;
            sig_d    = active_level(bus.edge_mode_i);
            strobe_d = 1'b1;
            busy_d   = 1'b1;
            ph_load  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          err_d = 1'b0;
        end
      end
      ST_ACT, ST_INACT: begin
        if (bus.stop_i) begin
          state_d = ST_IDLE;
          sig_d   = mode_q;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (!ph_tc) begin
          ph_en = 1'b1;
        end else if (state_q == ST_ACT) begin
          state_d = ST_INACT;
          sig_d   = mode_q;
          ph_load = 1'b1;
        end else if (more_pulses) begin
          state_d  = ST_ACT;
          sig_d    = active_level(mode_q);
          strobe_d = 1'b1;
          ph_load  = 1'b1;
          if (pulse_q != ALL1) begin
            pulse_d = pulse_q + ONE;
          end else begin
            pulse_d = pulse_q;
          end
        end else begin
          state_d = ST_IDLE;
          sig_d   = mode_q;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sig_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, configuration and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      sig_q    <= 1'b0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      mode_q   <= EDGE_RISE;
      period_q <= ZERO;
      width_q  <= ZERO;
      num_q    <= ZERO;
      pulse_q  <= ZERO;
    end else begin
      state_q  <= state_d;
      sig_q    <= sig_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      mode_q   <= mode_d;
      period_q <= period_d;
      width_q  <= width_d;
      num_q    <= num_d;
      pulse_q  <= pulse_d;
    end
  end

  assign bus.sig_o           = sig_q;
  assign bus.active_strobe_o = strobe_q;
  assign bus.busy_o          = busy_q;
  assign bus.done_o          = done_q;
  assign bus.cfg_err_o       = err_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Directed bench for pulse_train_gen: per-cycle waveform checks from a closed-form
// schedule plus a scoreboard of expected strobe/done/error cycles.
module tb_pulse_train_gen;
  import pulse_train_gen_pkg::*;

  localparam int CW = CNT_W_DEF;

  logic clk   = 1'b0;
  logic rst_i = 1'b1;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  int exp_strobe_q[$];
  int exp_done_q[$];
  int exp_err_q[$];
  int strobe_cnt = 0;

  logic det_mode = 1'b0;
  logic det_prev = 1'b0;
  int   det_cnt  = 0;

  pulse_train_gen_if #(.CNT_W(CW)) bus ();

  pulse_train_gen #(.CNT_W(CW)) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Receiving-side edge detector on the loopback.
  always @(posedge clk) begin
    det_prev <= bus.sig_o;
    if (det_mode ? (det_prev && !bus.sig_o) : (!det_prev && bus.sig_o)) det_cnt <= det_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: each status pulse must match the next expected cycle.
  always @(negedge clk) begin
    if (bus.active_strobe_o === 1'b1) begin
      strobe_cnt++;
      check("strobe_expected", 32'(exp_strobe_q.size() != 0), 32'd1);
      if (exp_strobe_q.size() != 0) check("strobe_cycle", 32'(cyc), 32'(exp_strobe_q.pop_front()));
    end
    if (bus.done_o === 1'b1) begin
      check("done_expected", 32'(exp_done_q.size() != 0), 32'd1);
      if (exp_done_q.size() != 0) check("done_cycle", 32'(cyc), 32'(exp_done_q.pop_front()));
    end
    if (bus.cfg_err_o === 1'b1) begin
      check("err_expected", 32'(exp_err_q.size() != 0), 32'd1);
      if (exp_err_q.size() != 0) check("err_cycle", 32'(cyc), 32'(exp_err_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic mode, input int p, input int w, input int n, output int s);
    bus.edge_mode_i = mode;
    bus.period_i    = CW'(p);
    bus.width_i     = CW'(w);
    bus.num_i       = CW'(n);
    bus.start_i     = 1'b1;
    s = cyc;
  endtask

  task automatic push_run(input int s, input int p, input int n);
    for (int j = 0; j < n; j++) exp_strobe_q.push_back(s + 1 + j * p);
    exp_done_q.push_back(s + 1 + n * p);
  endtask

  // Active level for the first w cycles of every period-long slot of the run.
  task automatic watch(input int s, input logic mode, input int p, input int w,
                       input int run_len, input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      int   k;
      logic exp_sig;
      logic exp_busy;
      tick();
      bus.start_i = 1'b0;
      bus.stop_i  = 1'b0;
      k = cyc - (s + 1);
      if (k >= 0 && k < run_len) begin
        exp_sig  = ((k % p) < w) ? ~mode : mode;
        exp_busy = 1'b1;
      end else begin
        exp_sig  = mode;
        exp_busy = 1'b0;
      end
      check($sformatf("sig@%0d", cyc), 32'(bus.sig_o), 32'(exp_sig));
      check($sformatf("busy@%0d", cyc), 32'(bus.busy_o), 32'(exp_busy));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int s;
    int s2;
    int c0;
    int d0;
    bus.start_i     = 1'b0;
    bus.stop_i      = 1'b0;
    bus.edge_mode_i = 1'b0;
    bus.period_i    = '0;
    bus.width_i     = '0;
    bus.num_i       = '0;
    repeat (3) tick();
    check("rst_sig", 32'(bus.sig_o), 32'd0);
    check("rst_busy", 32'(bus.busy_o), 32'd0);
    check("rst_done", 32'(bus.done_o), 32'd0);
    check("rst_strobe", 32'(bus.active_strobe_o), 32'd0);
    check("rst_err", 32'(bus.cfg_err_o), 32'd0);
    rst_i = 1'b0;

    // 1: basic run started in cycle 10
    while (cyc < 10) tick();
    start_run(1'b0, 5, 2, 3, s);
    push_run(s, 5, 3);
    watch(s, 1'b0, 5, 2, 15, 17);

    // 2: inverted polarity
    bus.edge_mode_i = 1'b1;
    repeat (2) tick();
    check("idle_high", 32'(bus.sig_o), 32'd1);
    start_run(1'b1, 4, 1, 2, s);
    push_run(s, 4, 2);
    watch(s, 1'b1, 4, 1, 8, 10);

    // 3: rejected configurations
    start_run(1'b1, 6, 0, 1, s);
    exp_err_q.push_back(s + 1);
    watch(s, 1'b1, 6, 0, 0, 2);
    start_run(1'b1, 6, 6, 1, s);
    exp_err_q.push_back(s + 1);
    watch(s, 1'b1, 6, 6, 0, 2);
    start_run(1'b1, 1, 1, 1, s);
    exp_err_q.push_back(s + 1);
    watch(s, 1'b1, 1, 1, 0, 2);

    // 4: continuous run aborted in the third cycle of pulse 4
    bus.edge_mode_i = 1'b0;
    repeat (2) tick();
    c0 = strobe_cnt;
    start_run(1'b0, 10, 5, 0, s);
    for (int j = 0; j < 4; j++) exp_strobe_q.push_back(s + 1 + j * 10);
    exp_done_q.push_back(s + 34);
    watch(s, 1'b0, 10, 5, 33, 33);
    bus.stop_i = 1'b1;
    watch(s, 1'b0, 10, 5, 33, 3);
    check("abort_strobes", 32'(strobe_cnt - c0), 32'd4);

    // 5: reset during ACT, then a normal run
    start_run(1'b0, 6, 3, 5, s);
    exp_strobe_q.push_back(s + 1);
    watch(s, 1'b0, 6, 3, 30, 2);
    rst_i = 1'b1;
    tick();
    check("mid_rst_sig", 32'(bus.sig_o), 32'd0);
    check("mid_rst_busy", 32'(bus.busy_o), 32'd0);
    check("mid_rst_done", 32'(bus.done_o), 32'd0);
    rst_i = 1'b0;
    tick();
    start_run(1'b0, 3, 1, 2, s2);
    push_run(s2, 3, 2);
    watch(s2, 1'b0, 3, 1, 6, 8);

    // 6: loopback into the detector, with an ignored start mid-run
    bus.edge_mode_i = 1'b1;
    det_mode        = 1'b1;
    repeat (3) tick();
    d0 = det_cnt;
    c0 = strobe_cnt;
    start_run(1'b1, 8, 4, 100, s);
    push_run(s, 8, 100);
    watch(s, 1'b1, 8, 4, 800, 20);
    bus.period_i = CW'(5);
    bus.width_i  = CW'(2);
    bus.num_i    = CW'(1);
    bus.start_i  = 1'b1;
    watch(s, 1'b1, 8, 4, 800, 1);
    watch(s, 1'b1, 8, 4, 800, 781);
    tick();
    check("loop_det_count", 32'(det_cnt - d0), 32'd100);
    check("loop_strobes", 32'(strobe_cnt - c0), 32'd100);
    bus.start_i = 1'b1;
    bus.stop_i  = 1'b1;
    watch(s, 1'b1, 8, 4, 800, 3);
    check("stop_start_strobes", 32'(strobe_cnt - c0), 32'd100);

    check("strobe_q_left", 32'(exp_strobe_q.size()), 32'd0);
    check("done_q_left", 32'(exp_done_q.size()), 32'd0);
    check("err_q_left", 32'(exp_err_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pulse_train_gen.md
Name: pulse_train_gen

Overview:
Transmit-side counterpart of the timer's external-edge input path. It generates a programmable pulse train on a single output pin: period, high/low time, polarity and pulse count are set per run, and the pin is driven from a register. The output is meant to drive an external pin or loopback, where an edge detector on the receiving end counts its active edges. The block has a start/stop handshake and busy/done status for the timer control logic.

Parameters:
CNT_W, 16, width of the period, width and pulse-count fields and of the internal counters.

Ports:
clk_i  in  1  system clock; single clock domain.
rst_i  in  1  synchronous, active-high reset.
start_i  in  1  start request; sampled only in IDLE.
stop_i  in  1  abort request; takes effect in any busy state.
edge_mode_i  in  1  0: idle low, pulses high (active edge = rise). 1: idle high, pulses low (active edge = fall).
period_i  in  CNT_W  pulse period in clk_i cycles.
width_i  in  CNT_W  active-level duration in clk_i cycles.
num_i  in  CNT_W  number of pulses; 0 means continuous until stop.
sig_o  out  1  generated waveform, registered.
active_strobe_o  out  1  one-cycle pulse in the same cycle sig_o first shows the active level.
busy_o  out  1  high from the first active cycle until the run ends.
done_o  out  1  one-cycle pulse at the end of a run (completed or aborted).
cfg_err_o  out  1  one-cycle pulse when a start is rejected.

Behaviour:
- Reset (synchronous, rst_i=1 at a clk_i edge) forces: state=IDLE, sig_o=0, active_strobe_o=0, busy_o=0, done_o=0, cfg_err_o=0, latched mode=0, all counters=0.
- rst_i has priority over every input, including mid-run. No done_o pulse is produced by reset.
- State machine states: IDLE, ACT (active level), INACT (inactive level).
- IDLE:
  - sig_o = registered edge_mode_i (tracks with 1-cycle latency).
  - Config is accepted only if period_i>=2, width_i>=1 and width_i<period_i.
- start_i=1 in IDLE, config valid, stop_i=0:
  - latch mode, period, width and num.
  - next cycle: state=ACT, sig_o=active level (~mode), active_strobe_o=1, busy_o=1, phase counter=1, pulse counter=1.
  - latency from start_i sample to first active edge on sig_o: 1 cycle.
- start_i=1 in IDLE, config invalid: cfg_err_o=1 for one cycle; stay IDLE; nothing latched.
- start_i while busy: ignored; no error is flagged.
- ACT: sig_o stays active for exactly width cycles, then moves to INACT; sig_o = inactive level (mode).
- INACT: lasts period-width cycles. At its end:
  - if num==0 or pulse counter<num: go to ACT, increment the pulse counter, pulse active_strobe_o.
  - else: go to IDLE, busy_o=0, done_o=1 in that cycle.
- Edge spacing: consecutive active edges are exactly period cycles apart. The last pulse always completes its full inactive phase before done_o.
- stop_i=1 in ACT or INACT:
  - next cycle: state=IDLE, sig_o=inactive level, busy_o=0, done_o=1.
  - any partial pulse is truncated.
  - stop_i in IDLE: no effect.
- Simultaneous events:
  - stop_i and start_i together in IDLE: stop wins; no start, no error.
  - stop_i in the same cycle a run would complete naturally: a single done_o pulse.
- Continuous mode (num==0): the pulse counter saturates rather than wraps. Runs until stop_i.
- Counts and counters: phase counter is CNT_W bits and resets to 1 on each phase entry. Maximum pulse count is 2^CNT_W-1.
- sig_o is glitch-free: driven directly from a flop, with no combinational path to the pin.
- System constraint: the receiving detector needs at least 2 cycles per level, so system software programs width>=2 and period-width>=2. The block itself enforces only the minimums listed above.

Decomposition:
- Shared timer package holds:
  - the state enum (IDLE/ACT/INACT).
  - the CNT_W default constant.
  - the mode encoding constants (EDGE_RISE=0, EDGE_FALL=1), shared with the edge detector.
- One sub-module is natural: phase_counter. It is a loadable up-counter with a terminal-count compare, used for the ACT and INACT durations.
- The pulse counter stays inline.

Test Plan:
1. Basic run: mode=0, period=5, width=2, num=3, start at cycle 10. Required: sig_o high in cycles 11-12, 16-17, 21-22; active_strobe_o at 11, 16, 21; done_o at 26; busy_o high 11-25.
2. Inverted run: mode=1, period=4, width=1, num=2. Required: idle-high sig_o; low in cycles 1 and 5 after start; 2 strobes; done_o 8 cycles after the first strobe.
3. Invalid configs: width=0, then width=period=6, then period=1. Required: cfg_err_o pulses once for each; busy_o stays 0; sig_o is unchanged.
4. Abort: continuous run (num=0, period=10, width=5), stop_i asserted in the 3rd cycle of pulse 4. Required: sig_o inactive and done_o=1 the next cycle; exactly 4 strobes counted.
5. Reset mid-run: rst_i=1 during ACT. Required: next cycle sig_o=0, busy_o=0, done_o=0. A following start_i works normally.
6. Loopback: sig_o wired into the edge detector with mode matched, period=8, width=4, num=100. Required: the detector's active strobe count is exactly 100; the start_i ignored while busy does not restart the run; stop_i+start_i issued together in IDLE does nothing.
